// File: rtl/sd_spi_arbiter_if.sv
// -----------------------------------------------------------------------------
// sd_spi_arbiter_if
//   Bundles every non-clock signal around sd_spi_arbiter: the two requester
//   ports and the link to the shared SD-card SPI byte engine.
//
//   slave  : the arbiter's view (requester + engine inputs in, grants/strobes out)
//   master : the surrounding system's view (requesters and engine wrapper)
//
//   Requester side : rq_req, rq_gnt, rq_cs, rq_send, rq_recv, rq_din0,
//                    rq_din1, rq_done, rq_dout, err
//   Engine side    : eng_send, eng_recv, eng_din, eng_dout, eng_ready, spi_cs
// -----------------------------------------------------------------------------
interface sd_spi_arbiter_if;
    logic [1:0] rq_req;
    logic [1:0] rq_gnt;
    logic [1:0] rq_cs;
    logic [1:0] rq_send;
    logic [1:0] rq_recv;
    logic [7:0] rq_din0;
    logic [7:0] rq_din1;
    logic [1:0] rq_done;
    logic [7:0] rq_dout;
    logic       err;
    logic       eng_send;
    logic       eng_recv;
    logic [7:0] eng_din;
    logic [7:0] eng_dout;
    logic       eng_ready;
    logic       spi_cs;

    modport slave (
        input  rq_req, rq_cs, rq_send, rq_recv, rq_din0, rq_din1,
        input  eng_dout, eng_ready,
        output rq_gnt, rq_done, rq_dout, err,
        output eng_send, eng_recv, eng_din, spi_cs
    );

    modport master (
        output rq_req, rq_cs, rq_send, rq_recv, rq_din0, rq_din1,
        output eng_dout, eng_ready,
        input  rq_gnt, rq_done, rq_dout, err,
        input  eng_send, eng_recv, eng_din, spi_cs
    );
endinterface

// File: rtl/sd_spi_arbiter.sv
// -----------------------------------------------------------------------------
// sd_spi_arbiter
//   Shares one SD-card SPI byte engine between two requesters. Grants the
//   engine to one owner at a time (round-robin on ties), drives the card
//   chip-select, sequences each byte through the engine's strobe/ready
//   handshake and watchdogs a stuck engine ready.
//
//   Parameters
//     TIMEOUT : cycles BUSY waits for eng_ready before giving up (3..255)
//   Ports
//     clk     : engine clock, all logic on the rising edge
//     rst_n   : synchronous active-low reset
//     bus     : sd_spi_arbiter_if.slave (requester and engine signals)
// -----------------------------------------------------------------------------
module sd_spi_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    sd_spi_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, GRANTED, GUARD1, GUARD2, BUSY, RELEASE
    } state_e;

    // BUSY gives up on the TIMEOUT-th cycle it has spent waiting for ready.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       last_owner_q, last_owner_d;   // doubles as the current owner
    logic [7:0] cnt_q, cnt_d;
    logic       is_recv_q, is_recv_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic [7:0] dout_q, dout_d;
    logic       err_q, err_d;
    logic       send_q, send_d;
    logic       recv_q, recv_d;
    logic [7:0] din_q, din_d;
    logic       cs_q, cs_d;

    logic       own_req, own_cs, own_send, own_recv;
    logic [7:0] own_din;
    logic [1:0] own_mask;
    logic       new_owner;

    // Only the current owner's signals are ever looked at; the other
    // requester's strobes fall on the floor.
    always_comb begin
        own_req  = bus.rq_req[last_owner_q];
        own_cs   = bus.rq_cs[last_owner_q];
        own_send = bus.rq_send[last_owner_q];
        own_recv = bus.rq_recv[last_owner_q];
        own_din  = last_owner_q ? bus.rq_din1 : bus.rq_din0;
        own_mask = last_owner_q ? 2'b10 : 2'b01;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        is_recv_d    = is_recv_q;
        gnt_d        = gnt_q;
        done_d       = 2'b00;
        dout_d       = dout_q;
        err_d        = err_q;
        send_d       = 1'b0;
        recv_d       = 1'b0;
        din_d        = din_q;
        cs_d         = cs_q;
        new_owner    = last_owner_q;

        unique case (state_q)
            IDLE: begin
                if (bus.rq_req != 2'b00) begin
                    // Tie goes to whoever did not own the bus last.
                    new_owner    = (bus.rq_req == 2'b11) ? ~last_owner_q : bus.rq_req[1];
                    last_owner_d = new_owner;
                    gnt_d        = new_owner ? 2'b10 : 2'b01;
                    state_d      = GRANTED;
                end
            end

            GRANTED: begin
                cs_d = ~own_cs;
                if ((own_send || own_recv) && bus.eng_ready) begin
                    // Send wins over a simultaneous receive.
                    send_d    = own_send;
                    recv_d    = ~own_send;
                    is_recv_d = ~own_send;
                    din_d     = own_send ? own_din : 8'hFF;
                    state_d   = GUARD1;
                end else if (!own_req) begin
                    cs_d    = 1'b1;
                    gnt_d   = 2'b00;
                    din_d   = 8'hFF;
                    state_d = RELEASE;
                end
            end

            // The engine needs a couple of cycles to drop ready after a
            // strobe, so ready is not trusted until BUSY.
            GUARD1: begin
                cnt_d   = 8'd0;
                state_d = GUARD2;
            end

            GUARD2: begin
                cnt_d   = 8'd0;
                state_d = BUSY;
            end

            BUSY: begin
                if (bus.eng_ready) begin
                    if (is_recv_q) begin
                        dout_d = bus.eng_dout;
                    end
                    done_d  = own_mask;
                    state_d = GRANTED;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    dout_d  = 8'hFF;
                    done_d  = own_mask;
                    state_d = GRANTED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RELEASE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            cnt_q        <= 8'd0;
            is_recv_q    <= 1'b0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            dout_q       <= 8'hFF;
            err_q        <= 1'b0;
            send_q       <= 1'b0;
            recv_q       <= 1'b0;
            din_q        <= 8'hFF;
            cs_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            is_recv_q    <= is_recv_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            dout_q       <= dout_d;
            err_q        <= err_d;
            send_q       <= send_d;
            recv_q       <= recv_d;
            din_q        <= din_d;
            cs_q         <= cs_d;
        end
    end

    assign bus.rq_gnt   = gnt_q;
    assign bus.rq_done  = done_q;
    assign bus.rq_dout  = dout_q;
    assign bus.err      = err_q;
    assign bus.eng_send = send_q;
    assign bus.eng_recv = recv_q;
    assign bus.eng_din  = din_q;
    assign bus.spi_cs   = cs_q;
endmodule

// File: tb/tb_sd_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_spi_arbiter
//   Self-checking bench for sd_spi_arbiter. A behavioural SPI engine answers
//   strobes after a programmable latency (or never, to force a timeout), and a
//   small transaction-level model (round-robin owner, last received byte,
//   sticky error, strobe-to-done latency) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_sd_spi_arbiter;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_spi_arbiter_if bus ();

    sd_spi_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int         m_last;
    logic [7:0] m_dout;
    logic       m_err;

    // Engine model controls.
    int         eng_lat   = 4;
    logic [7:0] eng_rx    = 8'h00;
    bit         eng_stuck = 1'b0;

    // Engine: sees a strobe one edge after the arbiter raised it, drops ready,
    // then raises it eng_lat cycles later (or holds it low while stuck).
    initial begin
        bus.eng_ready = 1'b1;
        bus.eng_dout  = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.eng_send || bus.eng_recv) begin
                #1 bus.eng_ready = 1'b0;
                if (eng_stuck) begin
                    while (eng_stuck) @(posedge clk);
                end else begin
                    repeat (eng_lat) @(posedge clk);
                end
                #1;
                bus.eng_dout  = eng_rx;
                bus.eng_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Round-robin pick: a lone requester wins, a tie goes to the non-last owner.
    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return 1 - m_last;
        return r[1] ? 1 : 0;
    endfunction

    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        bus.rq_req  = '0;
        bus.rq_cs   = '0;
        bus.rq_send = '0;
        bus.rq_recv = '0;
        bus.rq_din0 = '0;
        bus.rq_din1 = '0;
        @(posedge clk); #1;
        m_last = 1;
        m_dout = 8'hFF;
        m_err  = 1'b0;
        checks++; if (bus.rq_gnt !== 2'b00) begin errors++; $display("FAIL %s gnt: got %b expected 00", tag, bus.rq_gnt); end
        checks++; if (bus.rq_done !== 2'b00) begin errors++; $display("FAIL %s done: got %b expected 00", tag, bus.rq_done); end
        checks++; if (bus.rq_dout !== 8'hFF) begin errors++; $display("FAIL %s dout: got %h expected ff", tag, bus.rq_dout); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL %s err: got %b expected 0", tag, bus.err); end
        checks++; if ({bus.eng_send, bus.eng_recv} !== 2'b00) begin errors++; $display("FAIL %s strobes: got %b expected 00", tag, {bus.eng_send, bus.eng_recv}); end
        checks++; if (bus.eng_din !== 8'hFF) begin errors++; $display("FAIL %s eng_din: got %h expected ff", tag, bus.eng_din); end
        checks++; if (bus.spi_cs !== 1'b1) begin errors++; $display("FAIL %s spi_cs: got %b expected 1", tag, bus.spi_cs); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Must be called with the arbiter in IDLE; r is the full request vector.
    task automatic acquire(input logic [1:0] r, output int o, input string tag);
        bus.rq_req = r;
        bus.rq_cs  = r;
        @(posedge clk); #1;
        o = pick(r);
        m_last = o;
        checks++; if (bus.rq_gnt !== 2'(1 << o)) begin errors++; $display("FAIL %s gnt: got %b expected %b", tag, bus.rq_gnt, 2'(1 << o)); end
        checks++; if (bus.spi_cs !== 1'b1) begin errors++; $display("FAIL %s cs_at_grant: got %b expected 1", tag, bus.spi_cs); end
        @(posedge clk); #1;
        checks++; if (bus.spi_cs !== 1'b0) begin errors++; $display("FAIL %s cs_follow: got %b expected 0", tag, bus.spi_cs); end
    endtask

    // Owner drops its request; expect RELEASE then IDLE with grant off and CS high.
    task automatic release_bus(input int o, input string tag);
        bus.rq_req[o] = 1'b0;
        bus.rq_cs[o]  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++; if (bus.rq_gnt !== 2'b00) begin errors++; $display("FAIL %s gnt[%0d]: got %b expected 00", tag, k, bus.rq_gnt); end
            checks++; if (bus.spi_cs !== 1'b1) begin errors++; $display("FAIL %s cs[%0d]: got %b expected 1", tag, k, bus.spi_cs); end
        end
    endtask

    // One byte by owner o. The non-owner strobes randomly throughout and must
    // never produce engine activity.
    task automatic do_byte(input int o, input bit snd, input bit rcv, input logic [7:0] d,
                           input int lat, input logic [7:0] rx, input bit stuck,
                           input bit drop_req, input string tag);
        int         exp_cyc;
        logic [7:0] exp_din;
        logic [1:0] mask;
        bit         is_rx;
        mask    = 2'(1 << o);
        is_rx   = rcv && !snd;
        exp_din = snd ? d : 8'hFF;
        // Two guard cycles, then BUSY samples ready (or gives up after TIMEOUT).
        exp_cyc = stuck ? TIMEOUT + 2 : lat + 2;
        eng_lat   = lat;
        eng_rx    = rx;
        eng_stuck = stuck;
        if (o == 0) begin
            bus.rq_din0 = d;
            bus.rq_din1 = 8'($urandom);
        end else begin
            bus.rq_din1 = d;
            bus.rq_din0 = 8'($urandom);
        end
        bus.rq_send[o]     = snd;
        bus.rq_recv[o]     = rcv;
        bus.rq_send[1 - o] = 1'($urandom);
        bus.rq_recv[1 - o] = 1'($urandom);
        @(posedge clk); #1;
        bus.rq_send = '0;
        bus.rq_recv = '0;
        checks++; if ({bus.eng_send, bus.eng_recv} !== {snd, is_rx}) begin errors++; $display("FAIL %s strobe: got %b expected %b", tag, {bus.eng_send, bus.eng_recv}, {snd, is_rx}); end
        checks++; if (bus.eng_din !== exp_din) begin errors++; $display("FAIL %s eng_din: got %h expected %h", tag, bus.eng_din, exp_din); end
        for (int k = 1; k <= exp_cyc; k++) begin
            if (drop_req && k == 3) bus.rq_req[o] = 1'b0;
            bus.rq_send[1 - o] = 1'($urandom);
            bus.rq_recv[1 - o] = 1'($urandom);
            @(posedge clk); #1;
            checks++; if ({bus.eng_send, bus.eng_recv} !== 2'b00) begin errors++; $display("FAIL %s extra_strobe@%0d: got %b expected 00", tag, k, {bus.eng_send, bus.eng_recv}); end
            checks++; if (bus.rq_done !== ((k == exp_cyc) ? mask : 2'b00)) begin errors++; $display("FAIL %s done@%0d: got %b expected %b", tag, k, bus.rq_done, (k == exp_cyc) ? mask : 2'b00); end
        end
        bus.rq_send = '0;
        bus.rq_recv = '0;
        if (stuck) begin
            m_err  = 1'b1;
            m_dout = 8'hFF;
        end else if (is_rx) begin
            m_dout = rx;
        end
        checks++; if (bus.rq_dout !== m_dout) begin errors++; $display("FAIL %s dout: got %h expected %h", tag, bus.rq_dout, m_dout); end
        checks++; if (bus.err !== m_err) begin errors++; $display("FAIL %s err: got %b expected %b", tag, bus.err, m_err); end
        if (stuck) begin
            eng_stuck = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.rq_gnt !== 2'b00) begin errors++; $display("FAIL reset_idle gnt: got %b expected 00", bus.rq_gnt); end
        checks++; if (bus.spi_cs !== 1'b1) begin errors++; $display("FAIL reset_idle cs: got %b expected 1", bus.spi_cs); end
    endtask

    task automatic test_single_send();
        int o;
        acquire(2'b01, o, "send_grant");
        do_byte(o, 1'b1, 1'b0, 8'h40, 16, 8'h99, 1'b0, 1'b0, "send");
    endtask

    task automatic test_receive();
        do_byte(0, 1'b0, 1'b1, 8'h00, 5, 8'h01, 1'b0, 1'b0, "recv");
    endtask

    task automatic test_simultaneous();
        // Same-cycle strobe right after a done must be accepted too.
        do_byte(0, 1'b1, 1'b1, 8'hA5, 3, 8'h77, 1'b0, 1'b0, "both");
        @(posedge clk); #1;
        checks++; if (bus.rq_done !== 2'b00) begin errors++; $display("FAIL both_single_done: got %b expected 00", bus.rq_done); end
    endtask

    task automatic test_timeout();
        do_byte(0, 1'b0, 1'b1, 8'h00, 1, 8'h12, 1'b1, 1'b0, "timeout");
        do_byte(0, 1'b0, 1'b1, 8'h00, 6, 8'h3C, 1'b0, 1'b0, "after_timeout");
        release_bus(0, "timeout_release");
    endtask

    task automatic test_contention();
        int o;
        do_reset("cont_reset");
        acquire(2'b11, o, "cont_grant0");
        do_byte(o, 1'b1, 1'b0, 8'h11, 2, 8'h00, 1'b0, 1'b0, "cont_a0");
        do_byte(o, 1'b0, 1'b1, 8'h00, 4, 8'h22, 1'b0, 1'b0, "cont_a1");
        release_bus(o, "cont_rel0");
        acquire(2'b10, o, "cont_grant1");
        bus.rq_req[0] = 1'b1;
        bus.rq_cs[0]  = 1'b1;
        do_byte(o, 1'b1, 1'b0, 8'h33, 3, 8'h00, 1'b0, 1'b0, "cont_b0");
        do_byte(o, 1'b0, 1'b1, 8'h00, 1, 8'h44, 1'b0, 1'b0, "cont_b1");
        release_bus(o, "cont_rel1");
        acquire(2'b01, o, "cont_grant0_again");
        release_bus(o, "cont_rel2");
    endtask

    task automatic test_mid_byte_release();
        int o;
        do_reset("mid_reset");
        acquire(2'b10, o, "mid_grant");
        do_byte(o, 1'b0, 1'b1, 8'h00, 16, 8'hC3, 1'b0, 1'b1, "mid_byte");
        @(posedge clk); #1;
        checks++; if (bus.rq_gnt !== 2'b00) begin errors++; $display("FAIL mid_release gnt: got %b expected 00", bus.rq_gnt); end
        checks++; if (bus.spi_cs !== 1'b1) begin errors++; $display("FAIL mid_release cs: got %b expected 1", bus.spi_cs); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int         o;
        logic [1:0] r;
        bit         s;
        bit         v;
        do_reset("rand_reset");
        for (int round = 0; round < 4; round++) begin
            r = 2'($urandom_range(1, 3));
            acquire(r, o, "rand_grant");
            for (int n = 0; n < 8; n++) begin
                s = 1'($urandom);
                v = s ? 1'($urandom) : 1'b1;
                do_byte(o, s, v, 8'($urandom), int'($urandom_range(1, 12)), 8'($urandom),
                        1'b0, 1'b0, "rand_byte");
            end
            release_bus(o, "rand_release");
        end
    endtask

    task automatic test_reset_in_busy();
        int  o;
        bit  seen;
        acquire(2'b10, o, "rib_grant");
        eng_lat   = 30;
        eng_stuck = 1'b0;
        bus.rq_din1    = 8'h5A;
        bus.rq_send[1] = 1'b1;
        @(posedge clk); #1;
        bus.rq_send = '0;
        checks++; if (bus.eng_send !== 1'b1) begin errors++; $display("FAIL rib_strobe: got %b expected 1", bus.eng_send); end
        repeat (5) @(posedge clk);
        #1;
        do_reset("reset_in_busy");
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.eng_ready;
            checks++; if (bus.rq_done !== 2'b00) begin errors++; $display("FAIL rib_no_done@%0d: got %b expected 00", k, bus.rq_done); end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rib_engine_ready: got 0 expected 1 within 64 cycles"); end
    endtask

    initial begin
        test_reset();
        test_single_send();
        test_receive();
        test_simultaneous();
        test_timeout();
        test_contention();
        test_mid_byte_release();
        test_random();
        test_reset_in_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
